// File: rtl/core_pipe_pkg.sv
// rtl/core_pipe_pkg.sv - shared pipeline types, widths and the instruction length rule
package core_pipe_pkg;

    localparam int HW_W = 16;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            err;
        logic [HW_W-1:0] data;
    } hw_entry_t;

    // Low two bits 2'b11 mark a 32-bit instruction; everything else is 16-bit.
    function automatic logic instr_is_32(input logic [HW_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/core_pipe_fetch_buffer.sv
// rtl/core_pipe_fetch_buffer.sv - halfword realignment buffer between fetch and decode
module core_pipe_fetch_buffer
    import core_pipe_pkg::*;
#(
    parameter int             DEPTH_HW = 4,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            f_flush,
    input  logic [XLEN-1:0] f_flush_pc,
    input  logic            f_in_valid,
    output logic            f_in_ready,
    input  logic [XLEN-1:0] f_in_data,
    input  logic            f_in_error,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_instr,
    output logic            d_size,
    output logic            d_error,
    output logic [XLEN-1:0] d_pc
);

    localparam int CW = $clog2(DEPTH_HW + 1);

    hw_entry_t [DEPTH_HW-1:0] buf_q;
    hw_entry_t [DEPTH_HW-1:0] buf_n;
    hw_entry_t [DEPTH_HW+1:0] ext;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_n;
    logic [CW-1:0]            base;
    logic                     drop_hw;
    logic [XLEN-1:0]          pc;
    logic                     head_32;
    logic                     push;
    logic [1:0]               pop_n;
    logic [1:0]               push_n;

    // An errored head halfword is always emitted alone, whatever its length bits say.
    assign head_32    = instr_is_32(buf_q[0].data) && !buf_q[0].err;
    assign d_valid    = (count >= CW'(1)) && (!head_32 || count >= CW'(2));
    assign d_size     = d_valid && head_32;
    assign d_error    = d_valid && (buf_q[0].err || (head_32 && buf_q[1].err));
    assign d_instr    = !d_valid ? '0 :
                        head_32  ? {buf_q[1].data, buf_q[0].data} :
                                   {{(XLEN-HW_W){1'b0}}, buf_q[0].data};
    assign d_pc       = pc;
    assign f_in_ready = count <= CW'(DEPTH_HW - 2);

    assign push   = f_in_valid && f_in_ready;
    assign pop_n  = (d_valid && d_ready) ? (head_32 ? 2'd2 : 2'd1) : 2'd0;
    assign push_n = push ? (drop_hw ? 2'd1 : 2'd2) : 2'd0;
    assign base   = count - CW'(pop_n);

    always_comb begin
        count_n = base + CW'(push_n);
        ext     = '0;
        ext[DEPTH_HW-1:0] = buf_q;
        for (int i = 0; i < DEPTH_HW; i++) begin
            case (pop_n)
                2'd1:    buf_n[i] = ext[i+1];
                2'd2:    buf_n[i] = ext[i+2];
                default: buf_n[i] = buf_q[i];
            endcase
            // New halfwords land just above whatever survives this cycle's pop.
            if (push && drop_hw && i == int'(base)) begin
                buf_n[i] = '{err: f_in_error, data: f_in_data[31:16]};
            end else if (push && !drop_hw && i == int'(base)) begin
                buf_n[i] = '{err: f_in_error, data: f_in_data[15:0]};
            end else if (push && !drop_hw && i == int'(base) + 1) begin
                buf_n[i] = '{err: f_in_error, data: f_in_data[31:16]};
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            buf_q   <= '0;
            count   <= '0;
            drop_hw <= 1'b0;
            pc      <= PC_RESET;
        end else if (f_flush) begin
            count   <= '0;
            drop_hw <= f_flush_pc[1];
            pc      <= f_flush_pc & ~XLEN'(1);
        end else begin
            buf_q <= buf_n;
            count <= count_n;
            pc    <= pc + XLEN'({pop_n, 1'b0});
            if (push) begin
                drop_hw <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_pipe_fetch_buffer.sv
// tb/tb_core_pipe_fetch_buffer.sv - self-checking bench for core_pipe_fetch_buffer
module tb_core_pipe_fetch_buffer;

    localparam int DEPTH = 4;

    logic        g_clk = 1'b0;
    logic        g_reset, f_flush, f_in_valid, f_in_error, d_ready;
    logic [31:0] f_flush_pc, f_in_data;
    logic        f_in_ready, d_valid, d_size, d_error;
    logic [31:0] d_instr, d_pc;

    core_pipe_fetch_buffer #(.DEPTH_HW(DEPTH), .PC_RESET(32'h0)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .f_flush(f_flush), .f_flush_pc(f_flush_pc),
        .f_in_valid(f_in_valid), .f_in_ready(f_in_ready), .f_in_data(f_in_data),
        .f_in_error(f_in_error), .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr),
        .d_size(d_size), .d_error(d_error), .d_pc(d_pc)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        fl;
        logic [31:0] fpc;
        logic        iv;
        logic [31:0] dat;
        logic        ierr;
        logic        dr;
        logic        e_rdy;
        logic        e_dv;
        logic [31:0] e_instr;
        logic        e_size;
        logic        e_err;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        size;
        logic [31:0] pc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic fl, logic [31:0] fpc, logic iv, logic [31:0] dat,
                                logic ierr, logic dr, logic rdy, logic dv,
                                logic [31:0] ins, logic sz, logic de, logic [31:0] pc);
        vec_t v;
        v = '{fl, fpc, iv, dat, ierr, dr, rdy, dv, ins, sz, de, pc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        f_flush = 0; f_flush_pc = 0; f_in_valid = 0; f_in_data = 0; f_in_error = 0; d_ready = 0;
    endtask

    initial begin
        logic [31:0] spc;
        logic [15:0] lo, hi;
        logic [31:0] word;
        exp_t        e;
        int          widx, hw_cnt;
        logic        dr;
        localparam int NW = 12;

        // rows: inputs driven this cycle | outputs expected from the state before the edge
        tbl.push_back(mk(1, 'h100, 0, 0, 0, 0,               1, 0, 0, 0, 0, 'h0));
        tbl.push_back(mk(0, 0, 1, 'h00A00093, 0, 1,          1, 0, 0, 0, 0, 'h100));
        tbl.push_back(mk(0, 0, 1, 'h00108113, 0, 1,          1, 1, 'h00A00093, 1, 0, 'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'h00108113, 1, 0, 'h104));
        tbl.push_back(mk(1, 'h102, 0, 0, 0, 0,               1, 0, 0, 0, 0, 'h108));
        tbl.push_back(mk(0, 0, 1, 'h45050001, 0, 1,          1, 0, 0, 0, 0, 'h102));
        tbl.push_back(mk(0, 0, 1, 'h00934505, 0, 1,          1, 1, 'h4505, 0, 0, 'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'h4505, 0, 0, 'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 0, 0, 0, 0, 'h106));
        tbl.push_back(mk(0, 0, 1, 'h000000A0, 0, 1,          1, 0, 0, 0, 0, 'h106));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   0, 1, 'h00A00093, 1, 0, 'h106));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'h0, 0, 0, 'h10A));
        tbl.push_back(mk(0, 0, 1, 'hFFFF0003, 1, 0,          1, 0, 0, 0, 0, 'h10C));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'h3, 0, 1, 'h10C));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'hFFFF, 0, 1, 'h10E));
        tbl.push_back(mk(0, 0, 1, 'h00A00093, 0, 0,          1, 0, 0, 0, 0, 'h110));
        tbl.push_back(mk(1, 'h200, 1, 'h11111111, 0, 1,      1, 1, 'h00A00093, 1, 0, 'h110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 0, 0, 0, 0, 'h200));
        tbl.push_back(mk(1, 'hFFFFFFFF, 0, 0, 0, 1,          1, 0, 0, 0, 0, 'h200));
        tbl.push_back(mk(0, 0, 1, 'h00011234, 0, 1,          1, 0, 0, 0, 0, 'hFFFFFFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,                   1, 1, 'h1, 0, 0, 'hFFFFFFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 0, 'h0));

        idle();
        g_reset = 1;
        step();
        step();
        g_reset = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            f_flush = tbl[i].fl; f_flush_pc = tbl[i].fpc; f_in_valid = tbl[i].iv;
            f_in_data = tbl[i].dat; f_in_error = tbl[i].ierr; d_ready = tbl[i].dr;
            chk($sformatf("vec%0d", i),
                96'({f_in_ready, d_valid, d_instr, d_size, d_error, d_pc}),
                96'({tbl[i].e_rdy, tbl[i].e_dv, tbl[i].e_instr, tbl[i].e_size, tbl[i].e_err, tbl[i].e_pc}));
            step();
        end

        // Streaming under backpressure, checked through the scoreboard.
        idle();
        f_flush = 1; f_flush_pc = 32'h300;
        step();
        idle();
        spc = 32'h300; widx = 0; hw_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("stream_ready", 96'(f_in_ready), 96'(hw_cnt <= DEPTH - 2));
            if (cyc == 9) chk("stall_full", 96'(f_in_ready), 96'(0));
            dr = (cyc >= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            d_ready = dr;
            f_in_valid = (widx < NW);
            if (widx[0]) begin
                lo = {8'(widx), 8'h01};
                hi = {8'(widx), 8'h02};
                word = {hi, lo};
            end else begin
                word = {16'hBEE0 + 16'(widx), 8'(widx), 8'h13};
            end
            f_in_data = word;
            if (d_valid && dr) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", 96'({d_instr, d_pc}), 96'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_out", 96'({d_instr, d_size, d_error, d_pc}),
                        96'({e.instr, e.size, 1'b0, e.pc}));
                    hw_cnt -= e.size ? 2 : 1;
                end
            end
            if (f_in_valid && f_in_ready) begin
                if (widx[0]) begin
                    exp_q.push_back('{{16'h0, word[15:0]}, 1'b0, spc});
                    exp_q.push_back('{{16'h0, word[31:16]}, 1'b0, spc + 32'd2});
                end else begin
                    exp_q.push_back('{word, 1'b1, spc});
                end
                spc += 32'd4;
                widx++;
                hw_cnt += 2;
            end
            step();
            f_in_valid = 0;
            if (widx == NW && exp_q.size() == 0) break;
        end
        chk("stream_words", 96'(widx), 96'(NW));
        chk("stream_drain", 96'(exp_q.size()), 96'(0));

        // Reset mid-stream beats a concurrent flush and clears a pending drop_hw.
        idle();
        f_flush = 1; f_flush_pc = 32'h102;
        step();
        idle();
        f_in_valid = 1; f_in_data = 32'h12345678;
        step();
        g_reset = 1; f_flush = 1; f_flush_pc = 32'h206;
        step();
        idle();
        g_reset = 0;
        chk("rst_mid_state", 96'({f_in_ready, d_valid, d_instr, d_pc}), 96'({1'b1, 1'b0, 32'h0, 32'h0}));
        f_in_valid = 1; f_in_data = 32'h00A00093;
        step();
        idle();
        chk("rst_mid_first", 96'({d_valid, d_instr, d_size, d_error, d_pc}),
            96'({1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/core_pipe_fetch_buffer.md
Name: core_pipe_fetch_buffer

Overview:
- Halfword realignment buffer between the instruction fetch bus interface and the decode stage.
- Accepts 32-bit aligned fetch words, stores them as halfwords, and emits one complete 16- or 32-bit instruction per cycle together with its PC.
- Decode then extracts immediates from the emitted instruction.
- Handles 32-bit instructions that straddle word boundaries, halfword-aligned branch targets, and fetch bus errors.

Parameters:
- DEPTH_HW, 4, buffer capacity in halfwords. Legal values are 4 to 8.
- PC_RESET, 32'h0000_0000, PC loaded by reset.

Ports:
- g_clk  input  1  core clock.
- g_reset  input  1  synchronous, active-high reset.
- f_flush  input  1  discard all buffered halfwords and redirect to f_flush_pc.
- f_flush_pc  input  32  new PC. Bit 0 is ignored.
- f_in_valid  input  1  fetch word present.
- f_in_ready  output  1  buffer can accept a word this cycle.
- f_in_data  input  32  fetch word. The lower halfword is at the lower address.
- f_in_error  input  1  bus error for this word.
- d_valid  output  1  complete instruction available.
- d_ready  input  1  decode consumes the instruction.
- d_instr  output  32  instruction. Upper 16 bits are zero for a 16-bit instruction.
- d_size  output  1  1 = 32-bit, 0 = 16-bit.
- d_error  output  1  instruction contains a bus-errored halfword.
- d_pc  output  32  PC of d_instr.

Behaviour:
- State:
  - halfword array hw[0..DEPTH_HW-1], each entry 16 data bits plus 1 error bit; hw[0] is the oldest;
  - count register, 0..DEPTH_HW;
  - drop_hw flag;
  - pc register.
- Reset values: count=0, drop_hw=0, pc=PC_RESET. Consequently d_valid=0, d_instr=0, d_size=0, d_error=0, d_pc=PC_RESET, f_in_ready=1.
- Length rule: hw[0][1:0]==2'b11 means a 32-bit instruction; anything else is 16-bit.
- d_valid is high when any of the following holds:
  - count>=1 and hw[0] is 16-bit;
  - count>=1 and the hw[0] error bit is set;
  - count>=2 and hw[0] is 32-bit.
- Output fields while d_valid is high:
  - d_instr = {hw[1],hw[0]} for a 32-bit instruction, {16'b0,hw[0]} for a 16-bit instruction.
  - d_error = OR of the error bits of the consumed halfwords.
- When d_valid is low, d_instr, d_size and d_error are driven to 0.
- Errored first halfword: if the hw[0] error bit is set, emit it alone with d_size=0 and d_error=1, consuming one halfword. Decode raises the fault.
- Pop: a transfer occurs when d_valid && d_ready. It removes 1 (16-bit) or 2 (32-bit) halfwords and advances pc by 2 or 4. Wrap at 2^32 is modulo.
- f_in_ready = (count <= DEPTH_HW-2). It depends on registered state only, with no combinational path from d_ready.
- Push: a transfer occurs when f_in_valid && f_in_ready.
  - Normally both halfwords are written at slots count-pop and count-pop+1, with the error bit replicated to both.
  - If drop_hw=1, only the upper halfword is written and drop_hw clears.
- Push and pop in the same cycle are both performed; the new count is count - pop + push.
- Latency: a word accepted in cycle N is visible on d_* in cycle N+1. There is no bypass from input to output.
- Flush, in the cycle where f_flush=1:
  - count<=0, pc<={f_flush_pc[31:1],1'b0}, drop_hw<=f_flush_pc[1];
  - any push or pop in that cycle is ignored;
  - flush has priority over push and pop;
  - d_valid may still be high in the flush cycle, but the consumer must treat that cycle's output as cancelled.
- Reset has priority over flush. Reset asserted mid-stream discards the buffer contents and any pending drop_hw.
- Full: count==DEPTH_HW-1 or DEPTH_HW holds f_in_ready low. A pop in that cycle does not raise ready until the next cycle.
- Empty with a straddling instruction: count==1 and hw[0] is 32-bit gives d_valid=0, which persists until the next word arrives.

Decomposition:
- Add to the shared core_pipe_pkg:
  - function instr_is_32(hw) for the length rule, also used by decode;
  - localparams HW_W=16 and XLEN=32.
- No sub-module. The halfword array and control are a single always_ff plus combinational pop/push logic.

Test Plan:
- Reset then flush to 0x100 with 32-bit words 0x00A00093, 0x00108113 -> d_pc 0x100 (size 1), then 0x104 (size 1); first d_valid one cycle after the first accept.
- Flush to 0x102 with word 0x4505_0001 -> first instruction is 0x4505 (16-bit) at d_pc 0x102; the lower halfword is dropped.
- Straddle: words 0x0093_4505, then 0x0000_00A0 -> 0x4505 @pc, then 0x00A00093 @pc+2 with size 1. d_valid stays 0 between the words while count==1.
- d_ready held 0 with words streaming -> f_in_ready drops when count reaches DEPTH_HW-1. Released: no loss or duplication, PCs strictly +2/+4.
- Word with f_in_error=1 whose lower halfword is 0x0003 -> d_error=1, d_size=0, one halfword consumed. The next halfword is also emitted with error.
- f_flush with f_in_valid=1 and d_ready=1 in the same cycle -> the word is discarded, count=0 next cycle, and d_pc equals the flush target.
